// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the instruction-fetch stage.
//   XLEN          - default PC / instruction width
//   NOP_INST      - canonical NOP (addi x0, x0, 0) used for IF/ID bubbles
//   fetch_state_t - fetch FSM state encoding
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/acknowledge bus.
//   imem_req   - fetch request (master -> slave)
//   imem_addr  - word-aligned fetch address (master -> slave)
//   imem_ack   - one-cycle pulse, imem_rdata valid (slave -> master)
//   imem_rdata - fetched instruction (slave -> master)
interface fetch_unit_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n        - clock, asynchronous active-low reset
//   flush             - squash the register (highest priority)
//   if_id_write       - 0 holds every field
//   load              - a new instruction is available this cycle
//   load_pc/load_inst - the instruction to load
//   pc_if_id, inst_if_id, valid_if_id - register contents
// Without a load the register takes a bubble but keeps its PC.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_id_write,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_inst,
  output logic [XLEN-1:0] pc_if_id,
  output logic [XLEN-1:0] inst_if_id,
  output logic            valid_if_id
);

  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      inst_d  = NOP;
      valid_d = 1'b0;
    end else if (!if_id_write) begin
      // stalled: hold everything
    end else if (load) begin
      pc_d    = load_pc;
      inst_d  = load_inst;
      valid_d = 1'b1;
    end else begin
      inst_d  = NOP;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_if_id    = pc_q;
  assign inst_if_id  = inst_q;
  assign valid_if_id = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues fetches over the
// imem req/ack bus, buffers a returned instruction during a stall and drops
// fetches that were in flight when a redirect arrived.
//   clk, rst_n     - clock, asynchronous active-low reset
//   pc_write       - PC may advance
//   if_id_write    - IF/ID may load
//   flush          - redirect from EX; squash IF/ID and in-flight fetch
//   br_target      - redirect PC (low two bits ignored)
//   imem           - instruction memory bus (master side)
//   pc_if_id, inst_if_id, valid_if_id - IF/ID register
//   fetch_busy     - request outstanding with no ack this cycle
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            if_id_write,
  input  logic            flush,
  input  logic [XLEN-1:0] br_target,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] pc_if_id,
  output logic [XLEN-1:0] inst_if_id,
  output logic            valid_if_id,
  output logic            fetch_busy
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;

  logic            accept;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            load;
  logic [XLEN-1:0] load_pc;
  logic [XLEN-1:0] load_inst;

  // pc_write=0 with if_id_write=1 never counts as accept; the instruction
  // is buffered and IF/ID sees a bubble.
  assign accept   = pc_write & if_id_write;
  assign target   = br_target & ~XLEN'(3);
  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    drop_addr_d    = drop_addr_q;
    buf_pc_d       = buf_pc_q;
    buf_inst_d     = buf_inst_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    load           = 1'b0;
    load_pc        = pc_q;
    load_inst      = imem.imem_rdata;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (flush) pc_d = target;
      end

      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          if (flush) begin
            pc_d = target;
          end else if (accept) begin
            load = 1'b1;
            pc_d = pc_plus4;
          end else begin
            buf_pc_d   = pc_q;
            buf_inst_d = imem.imem_rdata;
            state_d    = HOLD;
          end
        end else if (flush) begin
          // The outstanding address must stay on the bus until its ack,
          // so remember it separately from the redirected PC.
          pc_d        = target;
          drop_addr_d = pc_q;
          state_d     = DROP;
        end
      end

      DROP: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = drop_addr_q;
        if (flush) pc_d = target;
        if (imem.imem_ack) state_d = REQ;
      end

      HOLD: begin
        if (flush) begin
          pc_d    = target;
          state_d = REQ;
        end else if (accept) begin
          load      = 1'b1;
          load_pc   = buf_pc_q;
          load_inst = buf_inst_q;
          pc_d      = pc_plus4;
          state_d   = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      buf_pc_q    <= '0;
      buf_inst_q  <= XLEN'(NOP_INST);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign fetch_busy = ((state_q == REQ) || (state_q == DROP)) && !imem.imem_ack;

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .if_id_write(if_id_write),
    .load       (load),
    .load_pc    (load_pc),
    .load_inst  (load_inst),
    .pc_if_id   (pc_if_id),
    .inst_if_id (inst_if_id),
    .valid_if_id(valid_if_id)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic [31:0] br_target;
  logic [31:0] pc_if_id;
  logic [31:0] inst_if_id;
  logic        valid_if_id;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.XLEN(32)) imem_bus ();

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_write   (pc_write),
    .if_id_write(if_id_write),
    .flush      (flush),
    .br_target  (br_target),
    .imem       (imem_bus.master),
    .pc_if_id   (pc_if_id),
    .inst_if_id (inst_if_id),
    .valid_if_id(valid_if_id),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic iw, input logic fl, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rdata);
    pc_write            = pw;
    if_id_write         = iw;
    flush               = fl;
    br_target           = tgt;
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic v);
    chk({tag, "_pc"}, pc_if_id, pc);
    chk({tag, "_inst"}, inst_if_id, inst);
    chk({tag, "_valid"}, {31'd0, valid_if_id}, {31'd0, v});
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr,
                         input logic busy);
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, imem_bus.imem_addr, addr);
    chk({tag, "_busy"}, {31'd0, fetch_busy}, {31'd0, busy});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    $display("step reset");
    chk_ifid("rst", 32'h0, 32'h13, 0);
    chk_bus("rst", 0, 32'h0, 0);

    // IDLE cycle after release
    @(negedge clk); rst_n = 1'b1;
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step idle");
    chk_bus("idle", 0, 32'h0, 0);

    // zero-wait fetches at 0x0, 0x4
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 1, 32'h00A0_0093);
    $display("step fetch 0x0");
    chk_bus("f0", 1, 32'h0, 0);
    @(negedge clk);
    chk_ifid("f0", 32'h0, 32'h00A0_0093, 1);
    drive(1, 1, 0, 32'h0, 1, 32'h0010_0113);
    $display("step fetch 0x4");
    chk_bus("f4", 1, 32'h4, 0);
    @(negedge clk);
    chk_ifid("f4", 32'h4, 32'h0010_0113, 1);

    // stall two cycles while the fetch at 0x8 returns
    drive(0, 0, 0, 32'h0, 1, 32'h0020_0193);
    $display("step stall ack 0x8");
    chk_bus("st_ack", 1, 32'h8, 0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    $display("step hold");
    chk_bus("hold", 0, 32'h0, 0);
    chk_ifid("hold", 32'h4, 32'h0010_0113, 1);
    @(negedge clk);
    chk_ifid("hold2", 32'h4, 32'h0010_0113, 1);
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step release");
    chk_bus("rel", 0, 32'h0, 0);
    @(negedge clk);
    chk_ifid("rel", 32'h8, 32'h0020_0193, 1);

    // request to 0xC outstanding, then redirect to 0x100 (low bits ignored)
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step wait 0xC");
    chk_bus("wc", 1, 32'hC, 1);
    @(negedge clk);
    chk_ifid("bubble", 32'h8, 32'h13, 0);
    drive(1, 1, 1, 32'h0000_0101, 0, 32'h0);
    $display("step flush to 0x100");
    chk_bus("fl", 1, 32'hC, 1);
    @(negedge clk);
    chk_ifid("drop", 32'h0, 32'h13, 0);
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step drop wait");
    chk_bus("drop", 1, 32'hC, 1);
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    $display("step drop ack");
    chk_bus("dack", 1, 32'hC, 0);
    @(negedge clk);
    chk_ifid("dack", 32'h0, 32'h13, 0);

    // flush coincident with ack
    drive(1, 1, 1, 32'h0000_0200, 1, 32'h1111_1111);
    $display("step flush+ack");
    chk_bus("fa", 1, 32'h100, 0);
    @(negedge clk);
    chk_ifid("fa", 32'h0, 32'h13, 0);
    drive(1, 1, 0, 32'h0, 1, 32'h3333_3333);
    $display("step fetch 0x200");
    chk_bus("f200", 1, 32'h200, 0);
    @(negedge clk);
    chk_ifid("f200", 32'h200, 32'h3333_3333, 1);

    // stall into HOLD, then flush while still stalled
    drive(0, 0, 0, 32'h0, 1, 32'h4444_4444);
    $display("step stall ack 0x204");
    chk_bus("f204", 1, 32'h204, 0);
    @(negedge clk);
    chk_ifid("h204", 32'h200, 32'h3333_3333, 1);
    drive(0, 0, 1, 32'h0000_0300, 0, 32'h0);
    $display("step flush in hold");
    chk_bus("hfl", 0, 32'h0, 0);
    @(negedge clk);
    chk_ifid("hfl", 32'h0, 32'h13, 0);
    drive(1, 1, 0, 32'h0, 1, 32'h5555_5555);
    $display("step fetch 0x300");
    chk_bus("f300", 1, 32'h300, 0);
    @(negedge clk);
    chk_ifid("f300", 32'h300, 32'h5555_5555, 1);

    // enter DROP, then reset asynchronously mid-DROP
    drive(1, 1, 1, 32'h0000_0400, 0, 32'h0);
    $display("step flush to 0x400");
    chk_bus("f400", 1, 32'h304, 1);
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step drop 0x304");
    chk_bus("d304", 1, 32'h304, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("step async reset");
    chk_bus("arst", 0, 32'h0, 0);
    chk_ifid("arst", 32'h0, 32'h13, 0);
    @(negedge clk); rst_n = 1'b1;
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    chk_bus("arst_idle", 0, 32'h0, 0);

    // restart at RESET_PC, then redirect to top of memory and wrap
    @(negedge clk);
    drive(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h7777_7777);
    $display("step restart + flush to top");
    chk_bus("restart", 1, 32'h0, 0);
    @(negedge clk);
    chk_ifid("top_fl", 32'h0, 32'h13, 0);
    drive(1, 1, 0, 32'h0, 1, 32'h6666_6666);
    $display("step fetch 0xFFFFFFFC");
    chk_bus("ftop", 1, 32'hFFFF_FFFC, 0);
    @(negedge clk);
    chk_ifid("ftop", 32'hFFFF_FFFC, 32'h6666_6666, 1);
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    $display("step wrap");
    chk_bus("wrap", 1, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
